// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if;
  logic [4:0] RS1D, RS2D;
  logic [4:0] RS1E, RS2E, RDE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic [4:0] RDM, RDW;
  logic       RegWriteM, RegWriteW;
  logic       MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE;
  logic       MemTimeout;

  modport master (
    output RS1D, RS2D, RS1E, RS2E, RDE, ResultSrcE, PCSrcE,
           RDM, RDW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, MemTimeout
  );

  modport slave (
    input  RS1D, RS2D, RS1E, RS2E, RDE, ResultSrcE, PCSrcE,
           RDM, RDW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, MemTimeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use/branch hazard and memory-wait stall control with timeout.
// Define HAZARD_PERF_EN to add saturating StallCount/FlushCount perf counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]  StallCount,
  output logic [31:0]  FlushCount
`endif
);

  // state | meaning
  // RUN   | no outstanding memory wait
  // MWAIT | memory access pending, counting wait cycles
  // ERR   | memory never answered; pipeline frozen until reset
  typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, ERR = 2'd2} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_stall, lw_stall;

  // x0 is hardwired to zero, so it is never a forwarding source
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wr_m, input logic [4:0] rd_m,
                                         input logic wr_w, input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          state_nxt    = MWAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
      MWAIT: begin
        if (hz.MemReadyM)
          state_nxt = RUN;
        else if (wait_cnt == WAIT_LAST)
          state_nxt = ERR;
        else
          wait_cnt_nxt = wait_cnt + 8'd1;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RDE != 5'd0) &&
               ((hz.RDE == hz.RS1D) || (hz.RDE == hz.RS2D));
    case (state)
      RUN:     mem_stall = hz.MemReqM && !hz.MemReadyM;
      MWAIT:   mem_stall = !hz.MemReadyM;
      ERR:     mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase

    // reset values: nothing held, both front-end registers cleared
    hz.ForwardAE  = 2'b00;
    hz.ForwardBE  = 2'b00;
    hz.StallF     = 1'b0;
    hz.StallD     = 1'b0;
    hz.StallE     = 1'b0;
    hz.StallM     = 1'b0;
    hz.FlushD     = 1'b1;
    hz.FlushE     = 1'b1;
    hz.MemTimeout = 1'b0;

    if (rst_n) begin
      hz.ForwardAE  = fwd_sel(hz.RS1E, hz.RegWriteM, hz.RDM, hz.RegWriteW, hz.RDW);
      hz.ForwardBE  = fwd_sel(hz.RS2E, hz.RegWriteM, hz.RDM, hz.RegWriteW, hz.RDW);
      hz.MemTimeout = (state == ERR);
      if (mem_stall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
      end else begin
        // a taken branch makes the stalled decode instruction wrong-path
        hz.StallF = lw_stall && !hz.PCSrcE;
        hz.StallD = lw_stall && !hz.PCSrcE;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = lw_stall || hz.PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (hz.StallD && (StallCount != 32'hFFFF_FFFF))
        StallCount <= StallCount + 32'd1;
      if (hz.FlushE && (FlushCount != 32'hFFFF_FFFF))
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed memory-wait sequences,
// and randomized stimulus against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if hz();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  hazard_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .hz(hz),
                                   .StallCount(stall_cnt), .FlushCount(flush_cnt));
`else
  hazard_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
`endif

  always #5 clk = ~clk;

  // reference model state: consecutive unanswered wait cycles and timeout flag
  int m_wait = 0;
  bit m_err  = 0;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       pc, rwm, rww;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (hz.RegWriteM && hz.RDM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RDW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mem_busy();
    return m_err || (!hz.MemReadyM && (m_wait > 0 || hz.MemReqM));
  endfunction

  function automatic logic [10:0] ref_out();
    bit load_use, busy;
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, mt;
    load_use = (hz.ResultSrcE == 2'b01) && (hz.RDE != 0) &&
               (hz.RDE == hz.RS1D || hz.RDE == hz.RS2D);
    busy = mem_busy();
    if (!rst_n) begin
      fa = 0; fb = 0; sf = 0; sd = 0; se = 0; sm = 0; fd = 1; fe = 1; mt = 0;
    end else begin
      fa = ref_fwd(hz.RS1E);
      fb = ref_fwd(hz.RS2E);
      mt = m_err;
      if (busy) begin
        sf = 1; sd = 1; se = 1; sm = 1; fd = 0; fe = 0;
      end else begin
        sf = load_use && !hz.PCSrcE; sd = sf; se = 0; sm = 0;
        fd = hz.PCSrcE; fe = load_use || hz.PCSrcE;
      end
    end
    return {fa, fb, sf, sd, se, sm, fd, fe, mt};
  endfunction

  function automatic logic [10:0] dut_out();
    return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
            hz.FlushD, hz.FlushE, hz.MemTimeout};
  endfunction

  function automatic logic [3:0] stalls();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM};
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_wait = 0; m_err = 0;
    end else if (!m_err) begin
      if (mem_busy()) begin
        m_wait++;
        if (m_wait > TO) m_err = 1;
      end else begin
        m_wait = 0;
      end
    end
  endtask

  // called at a negedge with inputs already applied; returns at the next negedge
  task automatic run_cycle(input string nm);
    #1;
    check(nm, 32'(dut_out()), 32'(ref_out()));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    hz.RS1D = 0; hz.RS2D = 0; hz.RS1E = 0; hz.RS2E = 0; hz.RDE = 0;
    hz.RDM = 0; hz.RDW = 0; hz.ResultSrcE = 0; hz.PCSrcE = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    m_wait = 0; m_err = 0;
    run_cycle("reset_model");
    check("reset_outputs", 32'(dut_out()), 32'({2'b00, 2'b00, 4'b0000, 2'b11, 1'b0}));
    run_cycle("reset_model2");
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd9, 5'd9, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{5'd7, 5'd0, 5'd3, 5'd3, 5'd7, 5'd3, 5'd3, 2'b01, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};

    idle_inputs();
    @(negedge clk);
    do_reset();

`ifdef HAZARD_PERF_EN
    hz.ResultSrcE = 2'b01; hz.RDE = 7; hz.RS1D = 7;
    for (int i = 0; i < 10; i++) run_cycle("perf_lw");
    idle_inputs();
    run_cycle("perf_idle");
    check("stall_count", stall_cnt, 32'd10);
    check("flush_count", flush_cnt, 32'd10);
`endif

    for (int i = 0; i < 10; i++) begin
      hz.RS1D = tbl[i].rs1d; hz.RS2D = tbl[i].rs2d; hz.RS1E = tbl[i].rs1e;
      hz.RS2E = tbl[i].rs2e; hz.RDE = tbl[i].rde; hz.RDM = tbl[i].rdm; hz.RDW = tbl[i].rdw;
      hz.ResultSrcE = tbl[i].rsrc; hz.PCSrcE = tbl[i].pc;
      hz.RegWriteM = tbl[i].rwm; hz.RegWriteW = tbl[i].rww;
      hz.MemReqM = 0; hz.MemReadyM = 0;
      #1;
      check($sformatf("vec%0d_out", i), 32'(dut_out()),
            32'({tbl[i].fa, tbl[i].fb, tbl[i].sf, tbl[i].sd, 2'b00, tbl[i].fd, tbl[i].fe, 1'b0}));
      @(posedge clk); model_update(); @(negedge clk);
    end

    // memory wait of 3 cycles, then ready ends the stall in the same cycle
    idle_inputs();
    hz.MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1; check($sformatf("mwait_stall%0d", i), 32'(stalls()), 32'hF);
      run_cycle("mwait_model");
    end
    hz.MemReadyM = 1;
    #1; check("mwait_ready_release", 32'(stalls()), 32'h0);
    run_cycle("mwait_ready_model");
    hz.MemReqM = 0; hz.MemReadyM = 0;
    #1; check("mwait_back_run", 32'(stalls()), 32'h0);
    run_cycle("mwait_run_model");

    // timeout: ERR after TO+1 edges, sticky until reset
    hz.MemReqM = 1; hz.MemReadyM = 0;
    for (int i = 0; i < TO + 1; i++) begin
      #1; check($sformatf("to_pre%0d", i), 32'(hz.MemTimeout), 32'd0);
      run_cycle("to_model");
    end
    hz.MemReqM = 0; hz.MemReadyM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("to_flag%0d", i), 32'(hz.MemTimeout), 32'd1);
      check($sformatf("to_stall%0d", i), 32'(stalls()), 32'hF);
      run_cycle("to_err_model");
    end
    #2; rst_n = 1'b0;
    #1;
    check("to_reset_clear", 32'({stalls(), hz.FlushD, hz.FlushE, hz.MemTimeout}), 32'b0000_11_0);
    m_wait = 0; m_err = 0;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    run_cycle("after_err_reset");

    // asynchronous reset mid-MWAIT
    hz.MemReqM = 1;
    run_cycle("async_enter");
    #2; check("async_pre", 32'(stalls()), 32'hF);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({stalls(), hz.FlushD, hz.FlushE, hz.MemTimeout}), 32'b0000_11_0);
    m_wait = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    hz.MemReqM = 0;
    #1; check("async_from_run", 32'(stalls()), 32'h0);
    run_cycle("async_model");

    // randomized stimulus against the model
    for (int n = 0; n < 800; n++) begin
      hz.RS1D = 5'($urandom_range(0, 3)); hz.RS2D = 5'($urandom_range(0, 3));
      hz.RS1E = 5'($urandom_range(0, 3)); hz.RS2E = 5'($urandom_range(0, 3));
      hz.RDE  = 5'($urandom_range(0, 3)); hz.RDM  = 5'($urandom_range(0, 3));
      hz.RDW  = 5'($urandom_range(0, 3));
      hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.PCSrcE    = ($urandom_range(0, 3) == 0);
      hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.MemReqM   = ($urandom_range(0, 2) == 0);
      hz.MemReadyM = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      run_cycle("random");
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, the number of memory-wait cycles after which the controller declares a timeout (range 2..255).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: RS1D, RS2D  in  5 each  source registers of the decode-stage instruction.
REQ-005 SHALL have ports: RS1E, RS2E, RDE  in  5 each  source and destination registers of the execute-stage instruction.
REQ-006 SHALL have ports: ResultSrcE  in  2  execute-stage result select, where 2'b01 means load.
REQ-007 SHALL have ports: PCSrcE  in  1  branch or jump taken in execute.
REQ-008 SHALL have ports: RDM, RDW  in  5 each  and  RegWriteM, RegWriteW  in  1 each  memory-stage and writeback-stage destination register and write enable.
REQ-009 SHALL have ports: MemReqM  in  1  memory-stage access request, and  MemReadyM  in  1  memory access-complete acknowledge.
REQ-010 SHALL have ports: ForwardAE, ForwardBE  out  2 each  operand forward select, where 00 means register file, 01 means writeback and 10 means memory.
REQ-011 SHALL have ports: StallF, StallD, StallE, StallM  out  1 each  hold enables for the pipeline stages.
REQ-012 SHALL have ports: FlushD, FlushE  out  1 each  synchronous clears for the fetch/decode and decode/execute pipeline registers.
REQ-013 SHALL have ports: MemTimeout  out  1  sticky memory-timeout flag.

Function
REQ-014 SHALL compute ForwardAE combinationally: 10 if RegWriteM, RDM!=0 and RDM==RS1E; otherwise 01 if RegWriteW, RDW!=0 and RDW==RS1E; otherwise 00. The memory stage has priority.
REQ-015 SHALL compute ForwardBE in the same way using RS2E.
REQ-016 SHALL hold a state register with states RUN, MWAIT and ERR, and an 8-bit wait counter.
REQ-017 SHALL transition from RUN to MWAIT, clearing the counter to 0, when MemReqM is 1 and MemReadyM is 0; otherwise it SHALL stay in RUN.
REQ-018 SHALL transition from MWAIT to RUN when MemReadyM is 1; otherwise to ERR when the counter equals TIMEOUT-1; otherwise it SHALL stay in MWAIT and increment the counter.
REQ-019 SHALL remain in ERR until reset, with MemTimeout=1 in ERR only.
REQ-020 SHALL define memStall as (RUN and MemReqM and !MemReadyM) or (MWAIT and !MemReadyM) or ERR, evaluated combinationally in the same cycle.
REQ-021 SHALL define lwStall as ResultSrcE==01 and RDE!=0 and (RDE==RS1D or RDE==RS2D).
REQ-022 SHALL, when memStall=1, drive StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0, overriding REQ-023 to REQ-025.
REQ-023 SHALL, when memStall=0, drive StallE=StallM=0 and StallF=StallD=lwStall and !PCSrcE, because a taken branch makes the stalled decode instruction wrong-path.
REQ-024 SHALL, when memStall=0, drive FlushD=PCSrcE.
REQ-025 SHALL, when memStall=0, drive FlushE=lwStall or PCSrcE.
REQ-026 SHALL treat MemReadyM=1 in MWAIT as ending the stall in that same cycle, with all stall outputs 0 combinationally in that cycle.
REQ-027 SHALL hold x0 (register 0) as never hazardous and never forwarded.

Reset
REQ-028 SHALL, while rst_n=0, force state to RUN, counter to 0 and MemTimeout to 0 immediately, asynchronously of clk.
REQ-029 SHALL, while rst_n=0, drive all Stall* to 0, FlushD=1, FlushE=1 and Forward*=00.
REQ-030 SHALL abandon any MWAIT or ERR state on reset assertion mid-operation; after release, the first clk edge evaluates from RUN.

Configuration
REQ-031 SHALL, with HAZARD_PERF_EN defined, add output ports StallCount (32 bits) and FlushCount (32 bits).
REQ-032 SHALL, with HAZARD_PERF_EN defined, increment StallCount each cycle StallD=1 and FlushCount each cycle FlushE=1 (outside reset), saturating at 32'hFFFFFFFF and resetting to 0 with rst_n.
REQ-033 SHALL, without HAZARD_PERF_EN, omit both counter ports and all counter logic.

Verification
REQ-034 SHALL cover: RS1E=5, RDM=5, RegWriteM=1, RDW=5, RegWriteW=1 -> ForwardAE=10; the same with RDM=0 -> ForwardAE=01.
REQ-035 SHALL cover: ResultSrcE=01, RDE=7, RS2D=7, PCSrcE=0 -> StallF=StallD=1 and FlushE=1; the same with PCSrcE=1 -> StallF=0, FlushD=1, FlushE=1.
REQ-036 SHALL cover: MemReqM=1 and MemReadyM=0 for 3 cycles, then MemReadyM=1 -> all Stall*=1 for 3 cycles, then 0 with state RUN.
REQ-037 SHALL cover: TIMEOUT=4, MemReqM=1 and MemReadyM=0 held -> ERR entered after 5 cycles, MemTimeout=1 and stalls stay 1 until rst_n=0 clears them.
REQ-038 SHALL cover: rst_n pulsed low asynchronously in MWAIT -> outputs immediately Stall*=0, FlushD=FlushE=1, MemTimeout=0.
REQ-039 SHALL cover: with HAZARD_PERF_EN, 10 lwStall cycles -> StallCount=10 and FlushCount=10.
